adder_serial_param: RTL and testbench
=====================================

# adder_serial_param

Parametrised digit-serial adder/subtractor for the single-cycle RISC datapath, the generalised successor of the fixed 16-bit ripple adder. It processes a WIDTH-bit operand pair DIGIT bits per clock and produces sum/difference, carry, signed overflow and zero flags. It trades latency for area in the multiplier/divider helper path. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback buffer.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per clock. DIGIT = WIDTH gives single-digit (latency 1) operation.
- CLK  in  1  the single clock; all state changes on its rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operands and mode are valid this cycle.
- IN_READY  out  1  block can accept operands (high only in IDLE).
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- Cin  in  1  carry-in (add mode only).
- SUB  in  1  0 = A+B+Cin; 1 = A−B (A + ~B + 1, Cin ignored).
- OUT_VALID  out  1  result registers hold a completed result.
- OUT_READY  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference, modulo 2^WIDTH.
- Cout  out  1  carry out of bit WIDTH−1 (in SUB mode, 1 = no borrow).
- V  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- Z  out  1  1 when S == 0.

## Operation
- N = WIDTH/DIGIT digit steps. A 0..N−1 step counter (clog2(N) bits, min 1) selects the digit.
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: IN_READY=1. On IN_VALID, capture A, B^{WIDTH{SUB}}, and carry = SUB ? 1 : Cin; clear counter; go to RUN.
- RUN: each cycle add the low DIGIT bits of the A/B shift registers plus the carry. Shift the DIGIT-bit sum into the S shift register from the top. Update carry and shift A/B right by DIGIT.
- On the step with counter = N−1: record the carry into the MSB (from within that digit) and the final carry, go to DONE, and load Cout, V and Z from the completed result.
- DONE: OUT_VALID=1; S, Cout, V and Z are held stable. When OUT_READY=1, go to IDLE.
- IN_VALID outside IDLE is ignored. Operands are not latched and there is no error.
- A, B, Cin and SUB are sampled only on the accept edge. Later changes do not affect the operation in flight.
- Outputs hold their last value after returning to IDLE, until the next DONE entry overwrites them.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, IN_READY=1, OUT_VALID=0, S=0, Cout=0, V=0, Z=0, counter=0, internal shift registers 0.
- Accept edge = rising CLK with IN_VALID & IN_READY.
- OUT_VALID rises exactly N rising edges after the accept edge. Example: WIDTH=16, DIGIT=4 gives 4 cycles; DIGIT=WIDTH gives 1 cycle.
- Result handoff edge = rising CLK with OUT_VALID & OUT_READY. IN_READY returns high after that edge.
- A new operand set cannot be accepted on the same edge as the handoff.
- Minimum issue interval is N+2 cycles with OUT_READY held high.
- Backpressure: with OUT_READY low, DONE is held indefinitely and IN_READY stays 0.
- RST_n low at any point, including mid-RUN or in DONE, aborts immediately to the reset values above. No partial result is ever presented.
- IN_READY and OUT_VALID are decoded from state only, with no combinational path from inputs.

## Test plan
- Default params. Add A=0x0012, B=0x0034, Cin=0, SUB=0 -> S=0x0046, Cout=0, V=0, Z=0; OUT_VALID high 4 edges after accept. Also A=0x00DE, B=0x00F0 -> S=0x01CE.
- Carry/zero: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Z=1, V=0. Then A=0x0000, B=0x0000, Cin=1 -> S=0x0001, Z=0.
- Overflow: A=0x7FFF, B=0x0001 -> S=0x8000, V=1, Cout=0. SUB with A=0x8000, B=0x0001 -> S=0x7FFF, V=1, Cout=1.
- Subtract: A=0x0034, B=0x0012, SUB=1, Cin=1 (ignored) -> S=0x0022, Cout=1. Then A=0x0012, B=0x0034 -> S=0xFFDE, Cout=0, V=0.
- Handshake: hold OUT_READY=0 for 5 cycles after OUT_VALID while driving IN_VALID=1 with A=0x1111 -> S stays stable, IN_READY=0, the new operand is not taken. Then OUT_READY=1 -> OUT_VALID falls, IN_READY rises the next cycle.
- Reset and parameter variants: assert RST_n=0 on the 2nd RUN cycle -> all outputs go to reset values, IN_READY=1; a following op A=0x0056, B=0x0078 -> S=0x00CE. Repeat scenario 1 with WIDTH=8, DIGIT=8 (latency 1) and WIDTH=32, DIGIT=1 (latency 32).

Source files
------------

// File: rtl/adder_serial_param.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// with valid/ready handshakes on both sides and carry, overflow and zero flags.
module adder_serial_param #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_sh_q;
   logic [WIDTH-1:0] s_q;
   logic             carry_q;
   logic             cout_q;
   logic             v_q;
   logic             z_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [DIGIT:0]   sum_d;
   logic             c_msb_d;
   logic [WIDTH-1:0] s_sh_d;
   logic             last_d;

   assign sum_d   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   // Carry into the top bit of this digit, recovered from its sum bit and operand bits.
   assign c_msb_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum_d[DIGIT-1];
   assign s_sh_d  = (s_sh_q >> DIGIT) | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
   assign last_d  = (cnt_q == CW'(N - 1));

   // Control FSM, digit datapath and registered result/flags.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CW{1'b0}};
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         s_sh_q      <= {WIDTH{1'b0}};
         s_q         <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (IN_VALID) begin
                  a_q        <= A;
                  b_q        <= B ^ {WIDTH{SUB}};
                  carry_q    <= SUB ? 1'b1 : Cin;
                  cnt_q      <= {CW{1'b0}};
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               s_sh_q  <= s_sh_d;
               carry_q <= sum_d[DIGIT];
               cnt_q   <= cnt_q + CW'(1);
               if (last_d) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  s_q         <= s_sh_d;
                  cout_q      <= sum_d[DIGIT];
                  v_q         <= c_msb_d ^ sum_d[DIGIT];
                  z_q         <= (s_sh_d == {WIDTH{1'b0}});
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign S         = s_q;
   assign Cout      = cout_q;
   assign V         = v_q;
   assign Z         = z_q;

endmodule

// File: tb/tb_adder_serial_param.sv
// Scoreboard bench for adder_serial_param: three parameter variants share one stimulus bus,
// expected results come from a whole-word arithmetic model.
module tb_adder_serial_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b;
   logic        cin, sub, in_valid, out_ready;
   int          sel;

   always #5 clk = ~clk;

   logic        ir0, ov0, co0, v0, z0;
   logic [15:0] s0;
   logic        ir1, ov1, co1, v1, z1;
   logic [7:0]  s1;
   logic        ir2, ov2, co2, v2, z2;
   logic [31:0] s2;

   adder_serial_param #(.WIDTH(16), .DIGIT(4)) u_w16 (
      .CLK(clk), .RST_n(rst_n), .IN_VALID(in_valid && (sel == 0)), .IN_READY(ir0),
      .A(a[15:0]), .B(b[15:0]), .Cin(cin), .SUB(sub), .OUT_VALID(ov0), .OUT_READY(out_ready),
      .S(s0), .Cout(co0), .V(v0), .Z(z0));

   adder_serial_param #(.WIDTH(8), .DIGIT(8)) u_w8 (
      .CLK(clk), .RST_n(rst_n), .IN_VALID(in_valid && (sel == 1)), .IN_READY(ir1),
      .A(a[7:0]), .B(b[7:0]), .Cin(cin), .SUB(sub), .OUT_VALID(ov1), .OUT_READY(out_ready),
      .S(s1), .Cout(co1), .V(v1), .Z(z1));

   adder_serial_param #(.WIDTH(32), .DIGIT(1)) u_w32 (
      .CLK(clk), .RST_n(rst_n), .IN_VALID(in_valid && (sel == 2)), .IN_READY(ir2),
      .A(a), .B(b), .Cin(cin), .SUB(sub), .OUT_VALID(ov2), .OUT_READY(out_ready),
      .S(s2), .Cout(co2), .V(v2), .Z(z2));

   logic        in_ready_m, out_valid_m, cout_m, v_m, z_m;
   logic [31:0] s_m;

   // Route the selected variant's outputs onto one observation bus.
   always_comb begin
      in_ready_m = ir0; out_valid_m = ov0; s_m = {16'd0, s0}; cout_m = co0; v_m = v0; z_m = z0;
      case (sel)
         1: begin
            in_ready_m = ir1; out_valid_m = ov1; s_m = {24'd0, s1}; cout_m = co1; v_m = v1; z_m = z1;
         end
         2: begin
            in_ready_m = ir2; out_valid_m = ov2; s_m = s2; cout_m = co2; v_m = v2; z_m = z2;
         end
         default: begin
            in_ready_m = ir0; out_valid_m = ov0; s_m = {16'd0, s0}; cout_m = co0; v_m = v0; z_m = z0;
         end
      endcase
   end

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        v;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s (sel=%0d): got 0x%0h expected 0x%0h", tag, sel, obs, exp);
      end
   endtask

   function automatic int w_cur();
      return (sel == 1) ? 8 : (sel == 2) ? 32 : 16;
   endfunction

   function automatic int lat_cur();
      return (sel == 1) ? 1 : (sel == 2) ? 32 : 4;
   endfunction

   function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic cv, input logic sv);
      exp_t        e;
      logic [63:0] mask, lo_mask, bb, c, full, lo;
      mask    = (64'd1 << w) - 64'd1;
      lo_mask = mask >> 1;
      bb      = sv ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
      c       = sv ? 64'd1 : {63'd0, cv};
      full    = ({32'd0, av} & mask) + bb + c;
      lo      = ({32'd0, av} & lo_mask) + (bb & lo_mask) + c;
      e.s     = 32'(full & mask);
      e.cout  = full[w];
      e.v     = lo[w-1] ^ full[w];
      e.z     = ((full & mask) == 64'd0);
      return e;
   endfunction

   task automatic wait_result(output bit seen);
      int cyc;
      cyc = 0;
      while (!out_valid_m && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val("latency", 32'(cyc), 32'(lat_cur()));
      seen = out_valid_m;
   endtask

   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic sv, input int hold);
      exp_t        e;
      bit          seen;
      logic [31:0] s_held;
      @(negedge clk);
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; out_ready = (hold == 0);
      check_val("in_ready_idle", {31'd0, in_ready_m}, 32'd1);
      sb.push_back(model(w_cur(), av, bv, cv, sv));
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
      wait_result(seen);
      if (seen) begin
         if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check_val("S", s_m, e.s);
            check_val("Cout", {31'd0, cout_m}, {31'd0, e.cout});
            check_val("V", {31'd0, v_m}, {31'd0, e.v});
            check_val("Z", {31'd0, z_m}, {31'd0, e.z});
         end
         check_val("in_ready_done", {31'd0, in_ready_m}, 32'd0);
      end
      s_held = s_m;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 32'h1111; b = 32'h0; sub = 1'b0; cin = 1'b0;
         @(negedge clk);
         check_val("hold_S", s_m, s_held);
         check_val("hold_in_ready", {31'd0, in_ready_m}, 32'd0);
         check_val("hold_out_valid", {31'd0, out_valid_m}, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check_val("handoff_out_valid", {31'd0, out_valid_m}, 32'd0);
      check_val("handoff_in_ready", {31'd0, in_ready_m}, 32'd1);
      check_val("after_S_kept", s_m, s_held);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_in_ready"}, {31'd0, in_ready_m}, 32'd1);
      check_val({tag, "_out_valid"}, {31'd0, out_valid_m}, 32'd0);
      check_val({tag, "_S"}, s_m, 32'd0);
      check_val({tag, "_flags"}, {29'd0, cout_m, v_m, z_m}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; sel = 0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      do_op(32'h0012, 32'h0034, 1'b0, 1'b0, 0);
      do_op(32'h00DE, 32'h00F0, 1'b0, 1'b0, 0);
      do_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, 0);
      do_op(32'h0000, 32'h0000, 1'b1, 1'b0, 0);
      do_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, 0);
      do_op(32'h8000, 32'h0001, 1'b0, 1'b1, 0);
      do_op(32'h0034, 32'h0012, 1'b1, 1'b1, 0);
      do_op(32'h0012, 32'h0034, 1'b0, 1'b1, 0);
      do_op(32'h1234, 32'h4321, 1'b0, 1'b0, 5);
      for (int i = 0; i < 4; i++)
         do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 0);

      // Abort in the second RUN cycle; nothing from that operation may surface.
      @(negedge clk);
      a = 32'h0011; b = 32'h0022; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      rst_n = 1'b1;
      do_op(32'h0056, 32'h0078, 1'b0, 1'b0, 0);
      check_val("sb_drained", 32'(sb.size()), 32'd0);

      sel = 1;
      do_op(32'h0012, 32'h0034, 1'b0, 1'b0, 0);
      do_op(32'h00FF, 32'h0001, 1'b0, 1'b0, 0);
      do_op(32'h0080, 32'h0001, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++)
         do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 0);

      sel = 2;
      do_op(32'h0012, 32'h0034, 1'b0, 1'b0, 0);
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      do_op(32'h00000012, 32'h00000034, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++)
         do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
